hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core: tracks destination registers of in-flight instructions and drives the execute stage's `i_forward_A`/`i_forward_B` select codes. Issues load-use stalls and bubbles, and flushes wrong-path instructions on a taken branch. Sits beside the ID/EX pipeline register, sees decode-stage fields, and controls PC, IF/ID and ID/EX enables and flushes. Keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, operand forwarding.
// Define HAZARD_FWD_EN for forwarding; otherwise every in-flight dependence stalls.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_rd_wren,
    input  logic             i_id_mem_rden,
    input  logic             i_ex_br_taken,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic [1:0]       o_forward_A,
    output logic [1:0]       o_forward_B,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

`ifdef HAZARD_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e           state_q;
    logic             ex_valid_q, ex_wren_q, ex_load_q;
    logic [4:0]       ex_rd_q;
    logic             mem_valid_q, mem_wren_q;
    logic [4:0]       mem_rd_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic hazard, stall;

    function automatic logic src_match(input logic v, input logic wren, input logic [4:0] rd,
                                       input logic [4:0] src, input logic used,
                                       input logic id_valid);
        return v && wren && (rd != 5'd0) && (rd == src) && used && id_valid;
    endfunction

    always_comb begin
        ex_m1  = src_match(ex_valid_q, ex_wren_q, ex_rd_q, i_id_rs1, i_id_rs1_used, i_id_valid);
        ex_m2  = src_match(ex_valid_q, ex_wren_q, ex_rd_q, i_id_rs2, i_id_rs2_used, i_id_valid);
        mem_m1 = src_match(mem_valid_q, mem_wren_q, mem_rd_q, i_id_rs1, i_id_rs1_used,
                           i_id_valid);
        mem_m2 = src_match(mem_valid_q, mem_wren_q, mem_rd_q, i_id_rs2, i_id_rs2_used,
                           i_id_valid);
        // Without forwarding any producer still in EX or MEM blocks the consumer.
        hazard = ((ex_m1 || ex_m2) && (ex_load_q || !FwdEn)) || ((mem_m1 || mem_m2) && !FwdEn);
        // A taken branch makes the stalled instruction wrong-path, so it wins.
        stall         = hazard && !i_ex_br_taken;
        o_pc_en       = !stall;
        o_if_id_en    = !stall;
        o_if_id_flush = i_ex_br_taken;
        o_id_ex_flush = i_ex_br_taken || stall;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StRun;
            ex_valid_q  <= 1'b0;
            ex_wren_q   <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rd_q     <= 5'd0;
            mem_valid_q <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_rd_q    <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                StRun:   if (stall) state_q <= StStall;
                StStall: if (!stall) state_q <= StRun;
                default: state_q <= StRun;
            endcase
            mem_valid_q <= ex_valid_q;
            mem_wren_q  <= ex_wren_q;
            mem_rd_q    <= ex_rd_q;
            if (o_id_ex_flush) begin
                ex_valid_q <= 1'b0;
                ex_wren_q  <= 1'b0;
                ex_load_q  <= 1'b0;
                ex_rd_q    <= 5'd0;
            end else begin
                ex_valid_q <= i_id_valid;
                ex_wren_q  <= i_id_rd_wren;
                ex_load_q  <= i_id_mem_rden;
                ex_rd_q    <= i_id_rd;
            end
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (i_ex_br_taken && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

`ifdef HAZARD_FWD_EN
    logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

    // EX producer (youngest) beats MEM; a load in EX never forwards, it stalls instead.
    always_comb begin
        fwd_a_d = 2'd0;
        fwd_b_d = 2'd0;
        if (ex_m1 && !ex_load_q) fwd_a_d = 2'd2;
        else if (mem_m1)         fwd_a_d = 2'd1;
        if (ex_m2 && !ex_load_q) fwd_b_d = 2'd2;
        else if (mem_m2)         fwd_b_d = 2'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fwd_a_q <= 2'd0;
            fwd_b_q <= 2'd0;
        end else if (o_id_ex_flush) begin
            fwd_a_q <= 2'd0;
            fwd_b_q <= 2'd0;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign o_forward_A = fwd_a_q;
    assign o_forward_B = fwd_b_q;
`else
    assign o_forward_A = 2'd0;
    assign o_forward_B = 2'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; forwarding scenarios follow HAZARD_FWD_EN.
module tb_hazard_ctrl;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, rs1_used, rs2_used, rd_wren, mem_rden, br_taken;
    logic [4:0]    rs1, rs2, rd;
    logic          pc_en, if_id_en, if_id_flush, id_ex_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int nchk = 0;
    int nfail = 0;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_id_rd(rd), .i_id_rd_wren(rd_wren), .i_id_mem_rden(mem_rden),
        .i_ex_br_taken(br_taken), .o_pc_en(pc_en), .o_if_id_en(if_id_en),
        .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_forward_A(fwd_a), .o_forward_B(fwd_b),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] s1, input logic u1,
                          input logic [4:0] s2, input logic u2, input logic [4:0] d,
                          input logic wr, input logic ld);
        id_valid = v; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
        rd = d; rd_wren = wr; mem_rden = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        br_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL reset_pc_en: got %b want 1", pc_en); end
        nchk++; if (if_id_en !== 1'b1) begin nfail++; $display("FAIL reset_if_id_en: got %b want 1", if_id_en); end
        nchk++; if (if_id_flush !== 1'b0) begin nfail++; $display("FAIL reset_if_id_flush: got %b want 0", if_id_flush); end
        nchk++; if (id_ex_flush !== 1'b0) begin nfail++; $display("FAIL reset_id_ex_flush: got %b want 0", id_ex_flush); end
        nchk++; if (fwd_a !== 2'd0) begin nfail++; $display("FAIL reset_fwd_a: got %0d want 0", fwd_a); end
        nchk++; if (fwd_b !== 2'd0) begin nfail++; $display("FAIL reset_fwd_b: got %0d want 0", fwd_b); end
        nchk++; if (stall_cnt !== 3'd0) begin nfail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        nchk++; if (flush_cnt !== 3'd0) begin nfail++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
    endtask

    // lw x0 then add x6,x0,x0: x0 never creates a dependence
    task automatic test_x0_no_match();
        do_reset();
        set_id(1, 2, 1, 0, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 1, 0, 1, 6, 1, 0);
        #1;
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL x0_pc_en: got %b want 1", pc_en); end
        nchk++; if (id_ex_flush !== 1'b0) begin nfail++; $display("FAIL x0_id_ex_flush: got %b want 0", id_ex_flush); end
        tick();
        nchk++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin nfail++; $display("FAIL x0_fwd: got %0d/%0d want 0/0", fwd_a, fwd_b); end
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID, branch taken at the same time
    task automatic test_branch_overrides_stall();
        do_reset();
        set_id(1, 2, 1, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        br_taken = 1'b1;
        #1;
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL br_pc_en: got %b want 1", pc_en); end
        nchk++; if (if_id_flush !== 1'b1) begin nfail++; $display("FAIL br_if_id_flush: got %b want 1", if_id_flush); end
        nchk++; if (id_ex_flush !== 1'b1) begin nfail++; $display("FAIL br_id_ex_flush: got %b want 1", id_ex_flush); end
        tick();
        br_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        nchk++; if (flush_cnt !== 3'd1) begin nfail++; $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); end
        nchk++; if (stall_cnt !== 3'd0) begin nfail++; $display("FAIL br_stall_cnt: got %0d want 0", stall_cnt); end
        nchk++; if (fwd_a !== 2'd0) begin nfail++; $display("FAIL br_fwd_a: got %0d want 0", fwd_a); end
    endtask

    // nine taken-branch cycles on a 3-bit counter must stop at 7
    task automatic test_flush_saturate();
        do_reset();
        br_taken = 1'b1;
        repeat (9) tick();
        br_taken = 1'b0;
        nchk++; if (flush_cnt !== 3'd7) begin nfail++; $display("FAIL sat_flush_cnt: got %0d want 7", flush_cnt); end
        nchk++; if (stall_cnt !== 3'd0) begin nfail++; $display("FAIL sat_stall_cnt: got %0d want 0", stall_cnt); end
        tick();
        nchk++; if (flush_cnt !== 3'd7) begin nfail++; $display("FAIL sat_hold: got %0d want 7", flush_cnt); end
    endtask

`ifdef HAZARD_FWD_EN
    // addi x5,x0,1 ; add x6,x5,x5
    task automatic test_fwd_back_to_back();
        do_reset();
        set_id(1, 0, 1, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 5, 1, 6, 1, 0);
        #1;
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL b2b_pc_en: got %b want 1", pc_en); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        nchk++; if (fwd_a !== 2'd2 || fwd_b !== 2'd2) begin nfail++; $display("FAIL b2b_fwd: got %0d/%0d want 2/2", fwd_a, fwd_b); end
        nchk++; if (stall_cnt !== 3'd0) begin nfail++; $display("FAIL b2b_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    // addi x5 ; addi x9 ; sub x7,x5,x1
    task automatic test_fwd_dist2();
        do_reset();
        set_id(1, 0, 1, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 0, 1, 0, 0, 9, 1, 0);
        tick();
        set_id(1, 5, 1, 1, 1, 7, 1, 0);
        #1;
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL d2_pc_en: got %b want 1", pc_en); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        nchk++; if (fwd_a !== 2'd1) begin nfail++; $display("FAIL d2_fwd_a: got %0d want 1", fwd_a); end
        nchk++; if (fwd_b !== 2'd0) begin nfail++; $display("FAIL d2_fwd_b: got %0d want 0", fwd_b); end
    endtask

    // lw x5,0(x2) ; add x6,x5,x1
    task automatic test_load_use();
        do_reset();
        set_id(1, 2, 1, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        #1;
        nchk++; if (pc_en !== 1'b0) begin nfail++; $display("FAIL lu_pc_en: got %b want 0", pc_en); end
        nchk++; if (id_ex_flush !== 1'b1) begin nfail++; $display("FAIL lu_id_ex_flush: got %b want 1", id_ex_flush); end
        tick();
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL lu_resume: got %b want 1", pc_en); end
        nchk++; if (fwd_a !== 2'd0) begin nfail++; $display("FAIL lu_bubble_fwd: got %0d want 0", fwd_a); end
        nchk++; if (stall_cnt !== 3'd1) begin nfail++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        nchk++; if (fwd_a !== 2'd1 || fwd_b !== 2'd0) begin nfail++; $display("FAIL lu_fwd: got %0d/%0d want 1/0", fwd_a, fwd_b); end
    endtask
`else
    // addi x5 ; add x6,x5,x0 -> two stall cycles
    task automatic test_nofwd_dist1();
        do_reset();
        set_id(1, 0, 1, 0, 0, 5, 1, 0);
        #1;
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL nd1_first_pc_en: got %b want 1", pc_en); end
        tick();
        set_id(1, 5, 1, 0, 1, 6, 1, 0);
        #1;
        nchk++; if (pc_en !== 1'b0) begin nfail++; $display("FAIL nd1_stall1_pc_en: got %b want 0", pc_en); end
        nchk++; if (if_id_en !== 1'b0) begin nfail++; $display("FAIL nd1_stall1_if_id_en: got %b want 0", if_id_en); end
        nchk++; if (id_ex_flush !== 1'b1) begin nfail++; $display("FAIL nd1_stall1_flush: got %b want 1", id_ex_flush); end
        tick();
        nchk++; if (pc_en !== 1'b0) begin nfail++; $display("FAIL nd1_stall2_pc_en: got %b want 0", pc_en); end
        tick();
        nchk++; if (pc_en !== 1'b1 || id_ex_flush !== 1'b0) begin nfail++; $display("FAIL nd1_release: got pc_en %b flush %b want 1 0", pc_en, id_ex_flush); end
        nchk++; if (stall_cnt !== 3'd2) begin nfail++; $display("FAIL nd1_stall_cnt: got %0d want 2", stall_cnt); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        nchk++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin nfail++; $display("FAIL nd1_fwd: got %0d/%0d want 0/0", fwd_a, fwd_b); end
    endtask

    // addi x5 ; addi x9 ; sub x7,x5,x1 -> one stall cycle
    task automatic test_nofwd_dist2();
        do_reset();
        set_id(1, 0, 1, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 0, 1, 0, 0, 9, 1, 0);
        #1;
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL nd2_unrelated: got %b want 1", pc_en); end
        tick();
        set_id(1, 5, 1, 1, 1, 7, 1, 0);
        #1;
        nchk++; if (pc_en !== 1'b0) begin nfail++; $display("FAIL nd2_stall: got %b want 0", pc_en); end
        tick();
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL nd2_release: got %b want 1", pc_en); end
        nchk++; if (stall_cnt !== 3'd1) begin nfail++; $display("FAIL nd2_stall_cnt: got %0d want 1", stall_cnt); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // reset pulled low during the second stall cycle
    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 0, 1, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 0, 1, 6, 1, 0);
        tick();
        nchk++; if (pc_en !== 1'b0 || stall_cnt !== 3'd1) begin nfail++; $display("FAIL mid_pre: got pc_en %b cnt %0d want 0 1", pc_en, stall_cnt); end
        #1 rst_n = 1'b0;
        #1;
        nchk++; if (pc_en !== 1'b1 || if_id_en !== 1'b1) begin nfail++; $display("FAIL mid_enables: got %b %b want 1 1", pc_en, if_id_en); end
        nchk++; if (id_ex_flush !== 1'b0 || if_id_flush !== 1'b0) begin nfail++; $display("FAIL mid_flushes: got %b %b want 0 0", id_ex_flush, if_id_flush); end
        nchk++; if (stall_cnt !== 3'd0) begin nfail++; $display("FAIL mid_stall_cnt: got %0d want 0", stall_cnt); end
        tick();
        rst_n = 1'b1;
        #1;
        nchk++; if (pc_en !== 1'b1) begin nfail++; $display("FAIL mid_after: got %b want 1", pc_en); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_x0_no_match();
        test_branch_overrides_stall();
        test_flush_saturate();
`ifdef HAZARD_FWD_EN
        test_fwd_back_to_back();
        test_fwd_dist2();
        test_load_use();
`else
        test_nofwd_dist1();
        test_nofwd_dist2();
        test_reset_mid_stall();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
